// File: rtl/arith_arbiter_if.sv
// Request/response and shared-unit bus between arith_arbiter and its clients.
// Two requesters share the handshake; the ALU side carries operands and Z.
interface arith_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_m0;
    logic [1:0]  req_m1;
    logic [7:0]  req_x0;
    logic [7:0]  req_x1;
    logic [7:0]  req_y0;
    logic [7:0]  req_y1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_z;
    logic        rsp_err;
    logic [1:0]  alu_m;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [15:0] alu_z;

    modport master (
        output req_valid, req_m0, req_m1,
        output req_x0, req_x1, req_y0, req_y1,
        output rsp_ready, alu_z,
        input  req_ready, rsp_valid, rsp_z, rsp_err,
        input  alu_m, alu_x, alu_y
    );

    modport slave (
        input  req_valid, req_m0, req_m1,
        input  req_x0, req_x1, req_y0, req_y1,
        input  rsp_ready, alu_z,
        output req_ready, rsp_valid, rsp_z, rsp_err,
        output alu_m, alu_x, alu_y
    );
endinterface

// File: rtl/arith_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub/mul unit between
// two requesters, with a configurable operand settle window.
module arith_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input logic            clk,
    input logic            rst,
    arith_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic        gnt_q;
    logic [3:0]  cnt;
    logic [1:0]  rsp_valid_q;
    logic [15:0] rsp_z_q;
    logic        rsp_err_q;
    logic [1:0]  alu_m_q;
    logic [7:0]  alu_x_q;
    logic [7:0]  alu_y_q;

    logic        gnt;
    logic        accept;
    logic [1:0]  ready_c;
    logic [1:0]  m_sel;
    logic [7:0]  x_sel;
    logic [7:0]  y_sel;

    // Under contention the requester not served last wins.
    always_comb begin
        gnt = bus.req_valid[1];
        if (bus.req_valid == 2'b11) gnt = ~last_grant;
        m_sel = gnt ? bus.req_m1 : bus.req_m0;
        x_sel = gnt ? bus.req_x1 : bus.req_x0;
        y_sel = gnt ? bus.req_y1 : bus.req_y0;
        accept = (state == IDLE) && !rst && (bus.req_valid != 2'b00);
        ready_c = 2'b00;
        if (accept) ready_c = gnt ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt_q       <= 1'b0;
            cnt         <= 4'd0;
            rsp_valid_q <= 2'b00;
            rsp_z_q     <= 16'd0;
            rsp_err_q   <= 1'b0;
            alu_m_q     <= 2'd0;
            alu_x_q     <= 8'd0;
            alu_y_q     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt;
                        gnt_q      <= gnt;
                        // Reserved op bypasses the unit entirely.
                        if (m_sel == 2'd3) begin
                            rsp_z_q     <= 16'd0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= gnt ? 2'b10 : 2'b01;
                            state       <= RESP;
                        end else begin
                            alu_m_q <= m_sel;
                            alu_x_q <= x_sel;
                            alu_y_q <= y_sel;
                            cnt     <= 4'(LATENCY - 1);
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        rsp_z_q     <= bus.alu_z;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_m     = alu_m_q;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
endmodule

// File: doc/arith_arbiter.md
# arith_arbiter

Two-port arbiter and sequencer that shares one `arithmetic_module` (combinational add/sub/multiply unit with `m`, `X`, `Y`, `Z`) between two independent requesters. It accepts operations over valid/ready handshakes and grants round-robin. It holds the unit's operands stable for a configurable settle window, captures `Z` into a response register, and returns the result to the granted requester over a second valid/ready handshake. It sits between the ALU datapath and its clients, such as a sequencer and a debug/host port.

## Interface
- `LATENCY`, default 1: number of cycles operands are held on the shared unit before `alu_z` is captured; legal range 1–15.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i set when requester i presents an operation.
- `req_ready` out 2: bit i is the accept strobe to requester i; at most one bit set per cycle.
- `req_m0`, `req_m1` in 2: op code per requester; 0 add, 1 sub, 2 multiply, 3 reserved.
- `req_x0`, `req_x1` in 8: operand X per requester.
- `req_y0`, `req_y1` in 8: operand Y per requester.
- `rsp_valid` out 2: bit i set while a result for requester i is pending.
- `rsp_ready` in 2: bit i set when requester i consumes its result.
- `rsp_z` out 16: result word, valid when any `rsp_valid` bit is set.
- `rsp_err` out 1: set with `rsp_valid` when the op was reserved (m=3).
- `alu_m` out 2, `alu_x` out 8, `alu_y` out 8: drive the shared unit's `m`, `X`, `Y`.
- `alu_z` in 16: the shared unit's `Z`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise grant: with one requester valid, grant it. With both valid, grant the one not equal to `last_grant`.
  - Assert `req_ready[g]` combinationally in the same cycle, latch the op/X/Y of requester g, update `last_grant <= g`.
  - If the latched m is 0–2, go to BUSY with `cnt <= LATENCY-1`. If m is 3, go to RESP with `rsp_z <= 0` and `rsp_err <= 1`; the unit is not used.
- BUSY:
  - `alu_m`/`alu_x`/`alu_y` are driven from the latched registers, constant for the whole state.
  - Decrement `cnt` each cycle. When `cnt == 0`, capture `rsp_z <= alu_z`, `rsp_err <= 0`, and go to RESP.
- RESP:
  - `rsp_valid[g] = 1`; `rsp_z` and `rsp_err` are held stable.
  - On `rsp_ready[g]` go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in BUSY and RESP. New requests wait, and their inputs are not sampled.
- Requesters must hold `req_*` stable while `req_valid` is set and not yet accepted.
- `rsp_z` passes `alu_z` through unmodified; width rules (zero-extended sum, 16-bit two's-complement difference, 16-bit product) belong to the shared unit.
- `alu_*` outputs hold their last latched value in IDLE and RESP.

## Timing
- Reset values: state IDLE, `last_grant = 1` (so requester 0 wins the first contention), `cnt = 0`, `req_ready = 0`, `rsp_valid = 0`, `rsp_z = 0`, `rsp_err = 0`, `alu_m = 0`, `alu_x = 0`, `alu_y = 0`.
- Accept cycle A (IDLE, handshake).
- BUSY occupies cycles A+1 … A+LATENCY; capture happens at the edge ending A+LATENCY.
- `rsp_valid` rises in cycle A+LATENCY+1. With `rsp_ready` already high, IDLE is reached at A+LATENCY+2.
- Minimum occupancy is LATENCY+2 cycles per op.
- Reserved op: `rsp_valid` in A+1, 2 cycles minimum.
- Back-to-back contention alternates grants 0,1,0,1…; a single active requester is granted every time.
- A `req_valid` that drops before acceptance is dropped silently, with no grant and no `last_grant` change.
- Reset mid-operation, in BUSY or RESP: the operation is discarded with no response, and all state and outputs return to reset values on the next edge.
- `rsp_ready` held low keeps RESP indefinitely; there is no timeout.

## Test plan
- Reset: hold `rst` 3 cycles with both `req_valid` set. `req_ready`, `rsp_valid`, `rsp_z`, and all `alu_*` stay 0. After release, requester 0 is accepted first.
- Single add, LATENCY=1: requester 0 sends m=0, X=100, Y=12. `req_ready[0]` is high in cycle A, `alu_x/y` are 100/12 in A+1, and `rsp_valid[0]` with `rsp_z = 112` appears in A+2.
- Contention: both valid continuously, requester 0 sends m=2, X=255, Y=1 and requester 1 sends m=1, X=50, Y=25. Grants alternate 0,1,0, results alternate 255/25, and no `req_ready` overlap occurs.
- Backpressure, LATENCY=3: requester 1 sends m=2, X=3, Y=5 and holds `rsp_ready[1] = 0` for 5 cycles. `rsp_z = 15` stays stable, requester 0's pending request is not accepted until one cycle after the `rsp_ready` handshake, and `alu_*` stay constant for exactly 3 BUSY cycles.
- Reserved op: m=3, X=10, Y=0. Response arrives one cycle after accept with `rsp_err = 1` and `rsp_z = 0`, and `alu_*` are unchanged.
- Reset mid-BUSY, LATENCY=4: assert `rst` in the 2nd BUSY cycle. No `rsp_valid` appears, and the next contention grants requester 0.
